// File: rtl/wave_capture_if.sv
// Sample-in / RAM-write / display-handshake bundle for the waveform capture block.
// Latency: none, wires only.
// Backpressure: none; samples are strobed and the display only reports idle.
interface wave_capture_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  new_sample_ready;
  logic [15:0]           new_sample_in;
  logic                  wave_display_idle;
  logic [ADDR_WIDTH:0]   write_address;
  logic                  write_enable;
  logic [7:0]            write_sample;
  logic                  read_index;

  // Driven by the sample source / display side.
  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  // Driven by the capture block.
  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Captures one rising-zero-crossing-aligned window of samples into a ping-pong RAM half.
// Latency: one cycle from a qualifying sample strobe to its RAM write pulse.
// Backpressure: none; samples outside a window are dropped, swaps wait for display idle.
module wave_capture #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  wave_capture_if.slave bus
);

  localparam logic [1:0] ARMED  = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] count;
  logic [15:0]           prev_sample;
  logic                  read_index;
  logic                  write_enable;
  logic [ADDR_WIDTH:0]   write_address;
  logic [7:0]            write_sample;

  logic                  trigger;
  logic [7:0]            display_sample;
  logic                  unused_bits;

  // Negative-to-non-negative crossing between the previous and current sample.
  assign trigger = bus.new_sample_ready && prev_sample[15] && !bus.new_sample_in[15];

  // Top byte with the sign flipped turns two's complement into offset binary.
  assign display_sample = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};

  // Only the sign of the previous sample and the top byte of the current one matter.
  assign unused_bits = ^{prev_sample[14:0], bus.new_sample_in[7:0]};

  // Window capture sequencing, write generation and half swapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ARMED;
      count         <= '0;
      prev_sample   <= 16'h0000;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= 8'h00;
    end else begin
      write_enable <= 1'b0;
      if (bus.new_sample_ready) begin
        prev_sample <= bus.new_sample_in;
      end
      case (state)
        ARMED: begin
          if (trigger) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {ADDR_WIDTH{1'b0}}};
            write_sample  <= display_sample;
            count         <= ADDR_WIDTH'(1);
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A new crossing here is just another sample of the current window.
          if (bus.new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= display_sample;
            count         <= count + ADDR_WIDTH'(1);
            if (count == {ADDR_WIDTH{1'b1}}) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Swap only during display blanking so a frame never shows a partial window.
          if (bus.wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

  assign bus.read_index    = read_index;
  assign bus.write_enable  = write_enable;
  assign bus.write_address = write_address;
  assign bus.write_sample  = write_sample;

endmodule

// File: tb/tb_wave_capture.sv
// Randomised and directed bench for wave_capture against a window-position model.
// Latency: checks each write one cycle after its strobe.
// Backpressure: none; strobes are never back to back.
module tb_wave_capture;
  localparam int AW = 3;
  localparam int N  = 1 << AW;

  logic clk;
  logic reset;

  wave_capture_if #(.ADDR_WIDTH(AW)) bus ();

  wave_capture #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pos = -1 waiting for a crossing, 0..N-1 next index to write, N window done.
  int          m_pos;
  int          m_half;
  int          m_prev;
  logic        m_we;
  int          m_addr;
  int          m_data;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int to_display(input int s);
    return ((s >>> 8) + 128) & 255;
  endfunction

  task automatic model_reset();
    m_pos  = -1;
    m_half = 0;
    m_prev = 0;
    m_we   = 1'b0;
  endtask

  task automatic model_edge(input logic rdy, input logic [15:0] smp, input logic idle);
    int s;
    s    = int'($signed(smp));
    m_we = 1'b0;
    if (m_pos == N) begin
      if (idle) begin
        m_half = 1 - m_half;
        m_pos  = -1;
      end
    end else if (rdy) begin
      if (m_pos == -1) begin
        if (m_prev < 0 && s >= 0) begin
          m_we   = 1'b1;
          m_addr = (1 - m_half) * N;
          m_data = to_display(s);
          m_pos  = 1;
        end
      end else begin
        m_we   = 1'b1;
        m_addr = (1 - m_half) * N + m_pos;
        m_data = to_display(s);
        m_pos  = m_pos + 1;
      end
    end
    if (rdy) m_prev = s;
  endtask

  task automatic step(input logic rdy, input logic [15:0] smp, input logic idle);
    @(negedge clk);
    bus.new_sample_ready  = rdy;
    bus.new_sample_in     = smp;
    bus.wave_display_idle = idle;
    @(posedge clk);
    model_edge(rdy, smp, idle);
    #1;
    check("write_enable", int'(bus.write_enable), int'(m_we));
    if (m_we) begin
      check("write_address", int'(bus.write_address), m_addr);
      check("write_sample", int'(bus.write_sample), m_data);
    end
    check("read_index", int'(bus.read_index), m_half);
  endtask

  task automatic send(input logic [15:0] smp, input logic idle);
    step(1'b1, smp, idle);
    step(1'b0, 16'h0000, idle);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    bus.new_sample_ready  = 1'b0;
    bus.wave_display_idle = 1'b0;
    model_reset();
    #1;
    check("rst_write_enable", int'(bus.write_enable), 0);
    check("rst_write_address", int'(bus.write_address), 0);
    check("rst_write_sample", int'(bus.write_sample), 0);
    check("rst_read_index", int'(bus.read_index), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    logic       last_rdy;
    logic       rdy;
    logic       idle;
    logic [15:0] smp;

    reset = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = 16'h0000;
    bus.wave_display_idle = 1'b0;
    model_reset();
    apply_reset();

    // No crossing from a reset prev of zero.
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);

    // First window into the upper half.
    send(16'hF000, 1'b0);
    send(16'h0010, 1'b0);
    for (int k = 1; k < N; k++) send(16'(k * 16'h1000), 1'b0);

    // Window done: crossings ignored until display idle.
    send(16'h8000, 1'b0);
    send(16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);

    // Second window into the lower half.
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    for (int k = 1; k < N; k++) send(16'(k * 16'h0900), 1'b0);

    // Idle coincides with a would-be crossing sample while done.
    send(16'hFFFF, 1'b0);
    step(1'b1, 16'h0005, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    send(16'h0006, 1'b0);

    // Abandon a window after three writes.
    send(16'h8000, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    apply_reset();
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h4000, 1'b0);

    // Random traffic with occasional resets.
    last_rdy = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rdy  = !last_rdy && ($urandom_range(0, 1) == 1);
      smp  = 16'($urandom_range(0, 65535));
      idle = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        last_rdy = 1'b0;
      end else begin
        step(rdy, smp, idle);
        last_rdy = rdy;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
